// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank write arbiter.
// Address map of the three-register bank and counter width.
package reg_bank_pkg;

    localparam int ADDR_W = 2;
    localparam int CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_Q0    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_Q1    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_Q2    = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_BCAST = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first eligible index at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] w,
    output logic          any
);

    logic found;
    int   idx;

    // scan from ptr upward, first eligible requester wins
    always_comb begin
        gnt   = '0;
        w     = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && elig[idx]) begin
                found    = 1'b1;
                w        = PW'(idx);
                gnt[idx] = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin shared write port for a three-register bank.
// Address 3 broadcasts one write into all three registers.
module reg_bank_write_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      addr,
    input  logic [DATA_W*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         q0,
    output logic [DATA_W-1:0]         q1,
    output logic [DATA_W-1:0]         q2,
    output logic [CNT_W-1:0]          wr_count
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [PW-1:0]      w;
    logic               any;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               we0;
    logic               we1;
    logic               we2;

    // a requester being acked this cycle must not be written twice
    assign elig = req & ~ack;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .elig (elig),
        .ptr  (ptr),
        .gnt  (gnt),
        .w    (w),
        .any  (any)
    );

    assign w_addr = addr[ADDR_W*w +: ADDR_W];
    assign w_data = wdata[DATA_W*w +: DATA_W];

    assign ptr_nxt = (w == PW'(NUM_REQ - 1)) ? '0 : w + PW'(1);

    // decode winner address into per-register write enables
    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        we2 = 1'b0;
        if (any) begin
            unique case (w_addr)
                ADDR_Q0:    we0 = 1'b1;
                ADDR_Q1:    we1 = 1'b1;
                ADDR_Q2:    we2 = 1'b1;
                ADDR_BCAST: begin
                    we0 = 1'b1;
                    we1 = 1'b1;
                    we2 = 1'b1;
                end
            endcase
        end
    end

    // commit one write, pulse ack, advance pointer and counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack      <= '0;
            ptr      <= '0;
            q0       <= '0;
            q1       <= '0;
            q2       <= '0;
            wr_count <= '0;
        end else begin
            ack <= gnt;
            if (any) begin
                ptr <= ptr_nxt;
                if (wr_count != CNT_MAX)
                    wr_count <= wr_count + 1'b1;
            end
            if (we0) q0 <= w_data;
            if (we1) q1 <= w_data;
            if (we2) q2 <= w_data;
        end
    end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed bench for reg_bank_write_arbiter.
// Vector table plus hand sequences for reset and saturation.
module tb_reg_bank_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int NV = 19;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [2*N-1:0]  addr;
    logic [DW*N-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   q0;
    logic [DW-1:0]   q1;
    logic [DW-1:0]   q2;
    logic [15:0]     wr_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic [2:0]  req;
        logic [5:0]  addr;
        logic [23:0] wdata;
        logic [2:0]  ack;
        logic [7:0]  q0;
        logic [7:0]  q1;
        logic [7:0]  q2;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt [NV];

    always #5 clk = ~clk;

    reg_bank_write_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .q0       (q0),
        .q1       (q1),
        .q2       (q2),
        .wr_count (wr_count)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag,
                             input logic [2:0] e_ack,
                             input logic [7:0] e_q0,
                             input logic [7:0] e_q1,
                             input logic [7:0] e_q2,
                             input logic [15:0] e_cnt);
        check({tag, " ack"}, 32'(ack), 32'(e_ack));
        check({tag, " q0"}, 32'(q0), 32'(e_q0));
        check({tag, " q1"}, 32'(q1), 32'(e_q1));
        check({tag, " q2"}, 32'(q2), 32'(e_q2));
        check({tag, " cnt"}, 32'(wr_count), 32'(e_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
        wdata = '0;

        // reset held with all requesting
        vt[0]  = '{1'b0, 3'b111, 6'b000000, 24'h302010, 3'b000, 8'h00, 8'h00, 8'h00, 16'd0};
        vt[1]  = '{1'b0, 3'b111, 6'b000000, 24'h302010, 3'b000, 8'h00, 8'h00, 8'h00, 16'd0};
        // release: round robin on q0
        vt[2]  = '{1'b1, 3'b111, 6'b000000, 24'h302010, 3'b001, 8'h10, 8'h00, 8'h00, 16'd1};
        vt[3]  = '{1'b1, 3'b111, 6'b000000, 24'h302010, 3'b010, 8'h20, 8'h00, 8'h00, 16'd2};
        vt[4]  = '{1'b1, 3'b111, 6'b000000, 24'h302010, 3'b100, 8'h30, 8'h00, 8'h00, 16'd3};
        vt[5]  = '{1'b1, 3'b111, 6'b000000, 24'h302010, 3'b001, 8'h10, 8'h00, 8'h00, 16'd4};
        // only req0/req2: skip req1, wrap pointer
        vt[6]  = '{1'b1, 3'b101, 6'b000000, 24'h302010, 3'b100, 8'h30, 8'h00, 8'h00, 16'd5};
        vt[7]  = '{1'b1, 3'b101, 6'b000000, 24'h302010, 3'b001, 8'h10, 8'h00, 8'h00, 16'd6};
        vt[8]  = '{1'b1, 3'b101, 6'b000000, 24'h302010, 3'b100, 8'h30, 8'h00, 8'h00, 16'd7};
        // idle
        vt[9]  = '{1'b1, 3'b000, 6'b000000, 24'h302010, 3'b000, 8'h30, 8'h00, 8'h00, 16'd7};
        // single master, one commit every 2 cycles
        vt[10] = '{1'b1, 3'b001, 6'b000001, 24'h0000A5, 3'b001, 8'h30, 8'hA5, 8'h00, 16'd8};
        vt[11] = '{1'b1, 3'b001, 6'b000001, 24'h0000A5, 3'b000, 8'h30, 8'hA5, 8'h00, 16'd8};
        vt[12] = '{1'b1, 3'b001, 6'b000001, 24'h0000A5, 3'b001, 8'h30, 8'hA5, 8'h00, 16'd9};
        vt[13] = '{1'b1, 3'b001, 6'b000001, 24'h0000A5, 3'b000, 8'h30, 8'hA5, 8'h00, 16'd9};
        // broadcast from req2
        vt[14] = '{1'b1, 3'b100, 6'b110000, 24'h3C0000, 3'b100, 8'h3C, 8'h3C, 8'h3C, 16'd10};
        vt[15] = '{1'b1, 3'b000, 6'b110000, 24'h3C0000, 3'b000, 8'h3C, 8'h3C, 8'h3C, 16'd10};
        // loser's broadcast address ignored until it wins
        vt[16] = '{1'b1, 3'b011, 6'b001110, 24'h00AA55, 3'b001, 8'h3C, 8'h3C, 8'h55, 16'd11};
        vt[17] = '{1'b1, 3'b011, 6'b001110, 24'h00AA55, 3'b010, 8'hAA, 8'hAA, 8'hAA, 16'd12};
        vt[18] = '{1'b1, 3'b000, 6'b001110, 24'h00AA55, 3'b000, 8'hAA, 8'hAA, 8'hAA, 16'd12};

        for (int i = 0; i < NV; i++) begin
            rst_n = vt[i].rst_n;
            req   = vt[i].req;
            addr  = vt[i].addr;
            wdata = vt[i].wdata;
            tick();
            check_all($sformatf("v%0d", i), vt[i].ack,
                      vt[i].q0, vt[i].q1, vt[i].q2, vt[i].cnt);
        end

        // reset in the cycle req1 would be acked
        req   = 3'b010;
        addr  = 6'b000100;
        wdata = 24'h007700;
        rst_n = 1'b0;
        tick();
        check_all("midrst", 3'b000, 8'h00, 8'h00, 8'h00, 16'd0);
        rst_n = 1'b1;
        tick();
        check_all("postrst", 3'b010, 8'h00, 8'h77, 8'h00, 16'd1);

        // two masters alternate: one commit per cycle up to FFFE
        req   = 3'b011;
        addr  = 6'b000000;
        wdata = 24'h000201;
        for (int i = 0; i < 65533; i++)
            tick();
        check("cnt_fffe", 32'(wr_count), 32'h0000FFFE);
        tick();
        check("sat1", 32'(wr_count), 32'h0000FFFF);
        tick();
        check("sat2", 32'(wr_count), 32'h0000FFFF);
        check("sat2 ack", 32'(ack), 32'h00000001);
        tick();
        check("sat3", 32'(wr_count), 32'h0000FFFF);
        check("sat3 ack", 32'(ack), 32'h00000002);
        check("sat3 q0", 32'(q0), 32'h00000002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Shares write access to a bank of three `DATA_W`-bit registers (`q0`, `q1`, `q2`) among `NUM_REQ` independent requesters. Each requester presents an address and data with a request/acknowledge handshake. A round-robin arbiter commits at most one write per cycle. Address 3 is a broadcast that loads the same data into all three registers in one cycle, which is the single-source fan-out load. The block sits between the configuration and control masters and the register bank they share.

## Interface
- `NUM_REQ`, 3 — number of requesters (2..8).
- `DATA_W`, 8 — register and data width.

- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `req` in NUM_REQ — per-requester write request, level.
- `addr` in 2*NUM_REQ — requester i uses `addr[2i+1:2i]`: 0=q0, 1=q1, 2=q2, 3=broadcast.
- `wdata` in DATA_W*NUM_REQ — requester i uses `wdata[DATA_W*i +: DATA_W]`.
- `ack` out NUM_REQ — registered one-cycle pulse: the request has been committed.
- `q0`, `q1`, `q2` out DATA_W each — register bank outputs, registered.
- `wr_count` out 16 — total committed writes, saturating at 16'hFFFF.

## Operation
- **Handshake**
  - Requester asserts `req[i]` and holds `addr`/`wdata` stable until it sees `ack[i]`=1.
  - It deasserts `req[i]` on the edge after `ack[i]`, or keeps it high to issue a new request with new addr/data.
- **Eligibility:** `elig = req & ~ack`. A requester whose `ack` is high this cycle is excluded, so a held request is never written twice.
- **Arbitration**
  - Combinational round-robin over `elig`, starting from pointer `ptr`.
  - Winner `w` is the first eligible index at or after `ptr`, wrapping modulo `NUM_REQ`.
- **Commit, at the clock edge, when any requester is eligible**
  - addr 0/1/2: only that register loads `wdata[w]`.
  - addr 3: `q0`, `q1` and `q2` all load `wdata[w]`.
  - `ack[w]` ← 1; all other `ack` bits ← 0.
  - `ptr` ← (w+1) mod `NUM_REQ`.
  - `wr_count` ← `wr_count`+1, unless already 16'hFFFF.
- **Idle cycle** (no eligible requester): registers, `ptr` and `wr_count` hold; `ack` ← 0.
- **Reset** (`rst_n`=0 at an edge):
  - `q0`/`q1`/`q2` ← 0, `ack` ← 0, `ptr` ← 0, `wr_count` ← 0.
  - Requests present during reset are ignored and not acknowledged.
  - A request in progress when reset hits stays pending and is re-arbitrated after reset release.
- **Boundary cases**
  - All requesters target the same register: writes are serialized in round-robin order, and the last committed value remains.
  - No same-cycle collision is possible, since only one write commits per cycle.
  - `addr` of a non-winning requester is ignored.

## Timing
- Request sampled in cycle N → register update and `ack` both visible in cycle N+1 (latency 1).
- Throughput:
  - One commit per cycle whenever at least one requester is eligible.
  - A single continuously requesting master gets one commit every 2 cycles, because its `ack` cycle masks it.
- Fairness: with k requesters continuously requesting, each is granted at least once every k commits.
- Reset has no asynchronous path. Outputs change only at `clk` edges.

## Structure
- Package `reg_bank_pkg`:
  - `ADDR_W`=2.
  - Constants `ADDR_Q0`=0, `ADDR_Q1`=1, `ADDR_Q2`=2, `ADDR_BCAST`=3.
  - `CNT_W`=16.
- Sub-module `rr_arbiter` (parameter `N`): inputs `elig` and `ptr`; outputs one-hot `gnt`, index `w`, `any`. Purely combinational.
- Top level holds `ptr`, `ack`, the bank registers, the address decode/broadcast write enables and `wr_count`.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles with `req`=3'b111 → `q0`=`q1`=`q2`=0, `ack`=0, `wr_count`=0 throughout. First release cycle with requests → `ack`=3'b001.
- **Single write:** req0, addr=1, data=8'hA5 → next cycle `q1`=8'hA5, `ack`=3'b001, `q0`/`q2` unchanged, `wr_count`=1. With req0 held, a second commit occurs 2 cycles later, never on consecutive cycles.
- **Broadcast:** req2, addr=3, data=8'h3C → next cycle `q0`=`q1`=`q2`=8'h3C, `ack`=3'b100, `wr_count`=1.
- **Round robin:** all three requesters continuously request addr 0 with data 8'h10/8'h20/8'h30 → `ack` sequence 001,010,100,001…, `q0` sequence 10,20,30.
- **Pointer wrap and skip:** after a grant to req2, only req0 and req2 request → req0 granted first (`ptr` wrapped to 0), then req2.
- **Saturation and mid-operation reset:**
  - Preload `wr_count` to 16'hFFFE via 65534 commits (or force in the bench), then 3 more commits → `wr_count` stays 16'hFFFF.
  - Assert `rst_n`=0 in the cycle req1 would be acked → no `ack`; `q` and count cleared. After release, req1 is acked and the write commits.
